i2c_status_irq: RTL and testbench

- Sits directly downstream of the I2C status register, on the APB side.
- Consumes the 13-bit registered status word and turns the sticky event bits into one maskable interrupt line.
- Generates the one-cycle `clear` pulse that starts the status register's read-to-clear sequence when the bus reads status.
- Tracks that sequence so the interrupt is never raised on stale sticky bits.

---
 rtl/i2c_status_irq.sv | 112 +++++++++++
 tb/tb_i2c_status_irq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_status_irq.sv
// Status-to-interrupt bridge: maskable irq, read-to-clear sequencing.
// Optional edge-mode irq with I2C_STATUS_IRQ_EDGE_EN.
module i2c_status_irq #(
  parameter int                   STATUS_W    = 13,
  parameter logic [STATUS_W-1:0]  STICKY_MASK = 13'h126D,
  parameter int                   CLR_LAT     = 3
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [STATUS_W-1:0] status_in,
  input  logic                rd_status,
  input  logic                wr_mask,
  input  logic [STATUS_W-1:0] mask_wdata,
  output logic [STATUS_W-1:0] mask_out,
  output logic                clear,
  output logic                clr_busy,
  output logic                irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLR  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic [STATUS_W-1:0] mask_q, mask_d;
  logic                clear_q, clear_d;
  logic                busy_q, busy_d;
  logic                irq_q, irq_d;
  logic [STATUS_W-1:0] src;
  logic                idle;

  assign idle = (state_q == S_IDLE);
  assign src  = status_in & mask_q & STICKY_MASK;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_pend_d = rd_pend_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (rd_status || rd_pend_q) begin
          state_d   = S_CLR;
          rd_pend_d = 1'b0;
        end
      end
      (state_q == S_CLR): begin
        cnt_d   = 4'(CLR_LAT);
        state_d = S_WAIT;
        if (rd_status) rd_pend_d = 1'b1;
      end
      (state_q == S_WAIT): begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_IDLE;
        if (rd_status) rd_pend_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mask_d  = wr_mask ? (mask_wdata & STICKY_MASK) : mask_q;
    clear_d = (state_d == S_CLR);
    busy_d  = (state_d != S_IDLE);
  end

`ifdef I2C_STATUS_IRQ_EDGE_EN
  logic [STATUS_W-1:0] prev_src_q, prev_src_d;

  // prev_src tracks even while busy so rises hidden by a clear are dropped
  always_comb begin
    prev_src_d = src;
    irq_d      = idle && |(src & ~prev_src_q);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) prev_src_q <= '0;
    else        prev_src_q <= prev_src_d;
  end
`else
  always_comb begin
    irq_d = idle && !rd_status && !rd_pend_q && |src;
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      mask_q    <= '0;
      clear_q   <= 1'b0;
      busy_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      mask_q    <= mask_d;
      clear_q   <= clear_d;
      busy_q    <= busy_d;
      irq_q     <= irq_d;
    end
  end

  assign mask_out = mask_q;
  assign clear    = clear_q;
  assign clr_busy = busy_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_i2c_status_irq.sv
// Bench for i2c_status_irq: directed steps plus random traffic
// against a cycle-timeline reference model.
module tb_i2c_status_irq;

  localparam int          W   = 13;
  localparam logic [12:0] STK = 13'h126D;
  localparam int          LAT = 3;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [W-1:0]  status_in = '0;
  logic          rd_status = 1'b0;
  logic          wr_mask = 1'b0;
  logic [W-1:0]  mask_wdata = '0;
  logic [W-1:0]  mask_out;
  logic          clear;
  logic          clr_busy;
  logic          irq;

  i2c_status_irq #(
    .STATUS_W(W), .STICKY_MASK(STK), .CLR_LAT(LAT)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .status_in(status_in), .rd_status(rd_status),
    .wr_mask(wr_mask), .mask_wdata(mask_wdata),
    .mask_out(mask_out), .clear(clear),
    .clr_busy(clr_busy), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: timeline of clear pulses, a pending flag, mask, last source.
  int          cyc = 0;
  int          last_clear = -1000;
  bit          m_pend = 0;
  logic [12:0] m_mask = '0;
  logic [12:0] m_prev = '0;
  logic        m_irq = 0;

  task automatic chk(string tag, logic [12:0] obs, logic [12:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_clear = -1000;
    m_pend = 0;
    m_mask = '0;
    m_prev = '0;
    m_irq = 0;
  endtask

  task automatic tick();
    bit          idle;
    logic [12:0] src;
    idle = (cyc > last_clear + LAT);
    src  = status_in & m_mask & STK;
`ifdef I2C_STATUS_IRQ_EDGE_EN
    m_irq  = idle && (|(src & ~m_prev));
    m_prev = src;
`else
    m_irq = idle && !rd_status && !m_pend && (|src);
`endif
    if (idle && (rd_status || m_pend)) begin
      last_clear = cyc + 1;
      m_pend = 0;
    end else if (rd_status) begin
      m_pend = 1;
    end
    if (wr_mask) m_mask = mask_wdata & STK;
    cyc++;
    @(posedge clk);
    #1;
    chk("irq", {12'd0, irq}, {12'd0, m_irq});
    chk("clear", {12'd0, clear}, {12'd0, 1'(last_clear == cyc)});
    chk("clr_busy", {12'd0, clr_busy},
        {12'd0, 1'(cyc >= last_clear && cyc <= last_clear + LAT)});
    chk("mask_out", mask_out, m_mask);
  endtask

  task automatic drive(logic rd, logic wm, logic [12:0] wd,
                       logic [12:0] st);
    rd_status  = rd;
    wr_mask    = wm;
    mask_wdata = wd;
    status_in  = st;
    tick();
    rd_status = 1'b0;
    wr_mask   = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irq", {12'd0, irq}, 13'd0);
    chk("rst_clear", {12'd0, clear}, 13'd0);
    chk("rst_busy", {12'd0, clr_busy}, 13'd0);
    chk("rst_mask", mask_out, 13'd0);
    n_rst = 1'b1;
    repeat (2) drive(0, 0, 0, 0);

    // mask write and events
    drive(0, 1, 13'h1FFF, 0);
    chk("mask_126d", mask_out, 13'h126D);
    drive(0, 0, 0, 13'h0004);
`ifndef I2C_STATUS_IRQ_EDGE_EN
    chk("irq_bit2", {12'd0, irq}, 13'd1);
`endif
    drive(0, 0, 0, 13'h0010);
    chk("irq_nonsticky", {12'd0, irq}, 13'd0);
    drive(0, 0, 0, 0);

    // read-clear sequence
    drive(0, 1, 13'h0200, 13'h0200);
    drive(0, 0, 0, 13'h0200);
    drive(1, 0, 0, 13'h0200);
    chk("rc_irq_t1", {12'd0, irq}, 13'd0);
    chk("rc_clear_t1", {12'd0, clear}, 13'd1);
    repeat (3) drive(0, 0, 0, 13'h0200);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("rc_irq_t6", {12'd0, irq}, 13'd0);
    repeat (2) drive(0, 0, 0, 0);

    // reads during busy collapse into one extra clear
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    repeat (8) drive(0, 0, 0, 0);

    // async reset mid-sequence
    drive(1, 1, 13'h1FFF, 13'h1FFF);
    drive(0, 0, 0, 13'h1FFF);
    n_rst = 1'b0;
    #1;
    chk("arst_clear", {12'd0, clear}, 13'd0);
    chk("arst_busy", {12'd0, clr_busy}, 13'd0);
    chk("arst_irq", {12'd0, irq}, 13'd0);
    chk("arst_mask", mask_out, 13'd0);
    model_reset();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    status_in = '0;
    repeat (6) drive(0, 0, 0, 0);

`ifdef I2C_STATUS_IRQ_EDGE_EN
    drive(0, 1, 13'h0001, 13'h0001);
    drive(0, 0, 0, 13'h0001);
    chk("edge_pulse", {12'd0, irq}, 13'd1);
    drive(0, 0, 0, 13'h0001);
    chk("edge_once", {12'd0, irq}, 13'd0);
    drive(0, 1, 13'h0001, 13'h0001);
    drive(0, 0, 0, 13'h0001);
    chk("edge_same_mask", {12'd0, irq}, 13'd0);
    drive(0, 1, 13'h0000, 13'h0001);
    drive(0, 1, 13'h0001, 13'h0001);
    drive(0, 0, 0, 13'h0001);
    chk("edge_reenable", {12'd0, irq}, 13'd1);
    drive(0, 0, 0, 0);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic        rd, wm;
      logic [12:0] wd, st;
      rd = ($urandom_range(0, 5) == 0);
      wm = ($urandom_range(0, 9) == 0);
      wd = 13'($urandom);
      st = ($urandom_range(0, 2) == 0) ? 13'($urandom)
                                         : (13'd1 << $urandom_range(0, 12));
      drive(rd, wm, wd, st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
